// File: rtl/res_sequencer.sv
// Residue-stage sequencer: walks NUM_ITER iterations, each a CLEAR cycle followed by
// NUM_WORDS RUN cycles, driving RAM addresses, carry mode and stage enables.
module res_sequencer #(
    parameter int RAM_ADDR_WIDTH = 7,
    parameter int NUM_WORDS      = 8,
    parameter int NUM_ITER       = 16
) (
    input  logic                      clk,
    input  logic                      asyn_reset,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      abort,
    output logic [1:0]                carry_out_control,
    output logic [RAM_ADDR_WIDTH-1:0] read_addr,
    output logic [RAM_ADDR_WIDTH-1:0] write_addr,
    output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
    output logic                      enable,
    output logic                      enable_shift,
    output logic                      enable_V_reg,
    output logic                      busy,
    output logic                      done
);

    localparam logic [RAM_ADDR_WIDTH-1:0] W_LAST = RAM_ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] I_LAST = RAM_ADDR_WIDTH'(NUM_ITER - 1);
    localparam logic [RAM_ADDR_WIDTH-1:0] ZERO   = '0;
    localparam logic [RAM_ADDR_WIDTH-1:0] ONE    = RAM_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] w_q, w_d;
    logic [RAM_ADDR_WIDTH-1:0] i_q, i_d;

    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            i_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            i_q     <= i_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        i_d     = i_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    w_d     = ZERO;
                    i_d     = ZERO;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    w_d     = ZERO;
                    i_d     = ZERO;
                end else if (!stall) begin
                    state_d = S_RUN;
                    w_d     = ZERO;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    w_d     = ZERO;
                    i_d     = ZERO;
                end else if (!stall) begin
                    if (w_q == W_LAST) begin
                        w_d = ZERO;
                        if (i_q == I_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_CLEAR;
                            i_d     = i_q + ONE;
                        end
                    end else begin
                        w_d = w_q + ONE;
                    end
                end
            end
            default: begin
                // DONE lasts one cycle whether or not abort or stall is seen
                state_d = S_IDLE;
                w_d     = ZERO;
                i_d     = ZERO;
            end
        endcase
    end

    always_comb begin
        carry_out_control = 2'd0;
        read_addr         = ZERO;
        write_addr        = ZERO;
        comp_cycle        = i_q;
        enable            = 1'b0;
        enable_shift      = 1'b0;
        enable_V_reg      = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        case (state_q)
            S_IDLE: begin
                comp_cycle = ZERO;
            end
            S_CLEAR: begin
                busy = 1'b1;
                if (stall) carry_out_control = 2'd3;
            end
            S_RUN: begin
                busy       = 1'b1;
                write_addr = w_q;
                read_addr  = (w_q == W_LAST) ? ZERO : w_q + ONE;
                if (stall) begin
                    carry_out_control = 2'd3;
                end else begin
                    carry_out_control = (w_q == W_LAST) ? 2'd2 : 2'd1;
                    enable            = 1'b1;
                    enable_shift      = 1'b1;
                    enable_V_reg      = (w_q == W_LAST);
                end
            end
            default: begin
                busy = 1'b1;
                done = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/res_sequencer.md
RES_SEQUENCER -- requirements
Module: res_sequencer

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 7: width of the address and comp_cycle outputs.
REQ-002 SHALL have parameter NUM_WORDS, default 8: 4-bit digit slices per operand; legal range 2..2^RAM_ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_ITER, default 16: iterations per operation; legal range 1..2^RAM_ADDR_WIDTH.
REQ-004 SHALL have port clk, in, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port asyn_reset, in, 1: reset is synchronous and active-high.
REQ-006 SHALL have port start, in, 1: one-cycle operation request, honoured only in IDLE.
REQ-007 SHALL have port stall, in, 1: freezes sequencing while high.
REQ-008 SHALL have port abort, in, 1: cancels the current operation.
REQ-009 SHALL have port carry_out_control, out, 2: carry mode to the residue stage (0 clear, 1 loop, 2 export, 3 hold).
REQ-010 SHALL have ports read_addr and write_addr, out, RAM_ADDR_WIDTH: residue RAM addresses.
REQ-011 SHALL have port comp_cycle, out, RAM_ADDR_WIDTH: current iteration index.
REQ-012 SHALL have ports enable, enable_shift, enable_V_reg, out, 1 each: residue stage enables.
REQ-013 SHALL have ports busy, out, 1, and done, out, 1: status; done is a one-cycle pulse.

Function
REQ-014 SHALL implement states IDLE, CLEAR, RUN, DONE, held in an internal state register plus word counter w (0..NUM_WORDS-1) and iteration counter i (0..NUM_ITER-1).
REQ-015 IDLE: carry_out_control=0, all enables 0, busy=0, addresses 0; start=1 -> CLEAR with i=0.
REQ-016 CLEAR (one cycle): carry_out_control=0, enables 0, read_addr=0 (prefetch word 0), busy=1; next state RUN with w=0.
REQ-017 RUN: write_addr=w, read_addr=w+1 (0 when w=NUM_WORDS-1), enable=1, enable_shift=1, busy=1; carry_out_control=1 when w<NUM_WORDS-1, 2 when w=NUM_WORDS-1.
REQ-018 RUN: enable_V_reg=1 only when w=NUM_WORDS-1.
REQ-019 RUN, w=NUM_WORDS-1: if i<NUM_ITER-1 -> CLEAR with i+1, else -> DONE; otherwise w increments.
REQ-020 DONE (one cycle): done=1, busy=1, carry_out_control=0, enables 0; next state IDLE.
REQ-021 comp_cycle SHALL equal i in every state; 0 in IDLE.
REQ-022 stall=1 in CLEAR or RUN: counters and state frozen, carry_out_control=3, enable/enable_shift/enable_V_reg=0, addresses held; outputs resume exactly on the first cycle stall=0.
REQ-023 stall SHALL have no effect in IDLE or DONE.
REQ-024 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse; abort takes priority over stall.
REQ-025 start while busy=1 SHALL be ignored; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-026 Unstalled operation length SHALL be NUM_ITER*(NUM_WORDS+1) busy cycles before DONE, plus the DONE cycle.
REQ-027 Counter arithmetic SHALL be RAM_ADDR_WIDTH bits wide with no wrap-around within legal parameter ranges.

Reset
REQ-028 asyn_reset=1 at a clock edge SHALL force IDLE, w=0, i=0, regardless of start, stall, abort.
REQ-029 After reset: carry_out_control=0, read_addr=0, write_addr=0, comp_cycle=0, enable=0, enable_shift=0, enable_V_reg=0, busy=0, done=0.
REQ-030 Reset mid-operation SHALL produce no done pulse; a start in the first post-reset cycle SHALL be honoured.

Verification (NUM_WORDS=4, NUM_ITER=3)
REQ-031 Single start pulse -> busy high 15 cycles; carry_out_control sequence per iteration 0,1,1,1,2; done on cycle 16; back in IDLE on cycle 17.
REQ-032 During RUN of iteration 1 -> comp_cycle=1, write_addr 0,1,2,3, read_addr 1,2,3,0, enable_V_reg only with write_addr=3.
REQ-033 stall high 3 cycles at RUN w=2 -> carry_out_control=3, enables 0, write_addr stays 2; total busy 18 cycles; sequence otherwise identical.
REQ-034 abort at RUN i=1, w=1 -> IDLE next cycle, busy=0, done never asserted, carry_out_control=0.
REQ-035 asyn_reset asserted at CLEAR of iteration 2 -> all outputs at REQ-029 values next cycle; a new start runs the full 15-cycle operation.
REQ-036 start re-pulsed during RUN -> no restart, done exactly once at cycle 16.
